// File: rtl/la_packet_decoder_pkg.sv
// Shared logic-analyser decoder types and constants.
// Imported by the packet decoder RTL and its bench.
package la_packet_decoder_pkg;

  typedef enum logic [2:0] {
    ST_HEAD0,
    ST_HEAD1,
    ST_OPCODE,
    ST_ARG0,
    ST_ARG1,
    ST_EMIT,
    ST_DROP
  } state_e;

  localparam logic [7:0]  OP_SET_SAMPLES  = 8'h01;
  localparam logic [15:0] DEFAULT_HEADER  = 16'hAA55;
  localparam logic [7:0]  DEFAULT_SAMPLES = 8'h80;

endpackage

// File: rtl/la_packet_decoder_if.sv
// Byte-stream in / command out handshake bundle.
// master drives bytes and takes commands; slave is the decoder side.
interface la_packet_decoder_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [7:0]  in_frag;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_arg;

  modport master (
    output in_valid, in_last, in_frag, cmd_ready,
    input  in_ready, cmd_valid, cmd_opcode, cmd_arg
  );

  modport slave (
    input  in_valid, in_last, in_frag, cmd_ready,
    output in_ready, cmd_valid, cmd_opcode, cmd_arg
  );

endinterface

// File: rtl/la_packet_decoder.sv
// 5-byte command packet decoder for the logic analyser.
// Error counter built only with LA_DECODER_ERRCNT_EN defined.
module la_packet_decoder
  import la_packet_decoder_pkg::*;
#(
  parameter logic [15:0] HEADER        = DEFAULT_HEADER,
  parameter logic [7:0]  SAMPLES_RESET = DEFAULT_SAMPLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic        io_in_bits_last,
  input  logic [7:0]  io_in_bits_fragment,
  output logic        io_cmd_valid,
  input  logic        io_cmd_ready,
  output logic [7:0]  io_cmd_opcode,
  output logic [15:0] io_cmd_arg,
  output logic [7:0]  io_samplesLeftAfterTrigger,
  output logic [7:0]  io_errorCount
);

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] arg_q, arg_d;
  logic [7:0]  samples_q, samples_d;
  logic        accept;
  logic        err_evt;
  logic        last;
  logic [7:0]  frag;

  assign last   = io_in_bits_last;
  assign frag   = io_in_bits_fragment;
  assign accept = io_in_valid && io_in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_HEAD0;
    else       state_q <= state_d;
  end

  // Next state: one step per accepted byte; errors resync via DROP
  always_comb begin
    state_d = state_q;
    err_evt = 1'b0;
    unique case (state_q)
      ST_HEAD0: if (accept) begin
        err_evt = (frag != HEADER[7:0]) || last;
        state_d = ST_HEAD1;
      end
      ST_HEAD1: if (accept) begin
        err_evt = (frag != HEADER[15:8]) || last;
        state_d = ST_OPCODE;
      end
      ST_OPCODE: if (accept) begin
        err_evt = last;
        state_d = ST_ARG0;
      end
      ST_ARG0: if (accept) begin
        err_evt = last;
        state_d = ST_ARG1;
      end
      ST_ARG1: if (accept) begin
        err_evt = !last;
        state_d = ST_EMIT;
      end
      ST_EMIT: if (io_cmd_ready) begin
        state_d = ST_HEAD0;
      end
      ST_DROP: if (accept && last) begin
        state_d = ST_HEAD0;
      end
      default: state_d = ST_HEAD0;
    endcase
    if (err_evt) state_d = last ? ST_HEAD0 : ST_DROP;
  end

  // Handshake outputs follow the state directly
  always_comb begin
    io_in_ready  = (state_q != ST_EMIT);
    io_cmd_valid = (state_q == ST_EMIT);
  end

  // Capture packet fields; set-samples commits with the ARG1 byte
  always_comb begin
    opcode_d  = opcode_q;
    arg_d     = arg_q;
    samples_d = samples_q;
    if (accept && state_q == ST_OPCODE && !last) begin
      opcode_d = frag;
    end
    if (accept && state_q == ST_ARG0 && !last) begin
      arg_d[7:0] = frag;
    end
    if (accept && state_q == ST_ARG1 && last) begin
      arg_d[15:8] = frag;
      if (opcode_q == OP_SET_SAMPLES) samples_d = arg_q[7:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q  <= 8'h0;
      arg_q     <= 16'h0;
      samples_q <= SAMPLES_RESET;
    end else begin
      opcode_q  <= opcode_d;
      arg_q     <= arg_d;
      samples_q <= samples_d;
    end
  end

  assign io_cmd_opcode              = opcode_q;
  assign io_cmd_arg                 = arg_q;
  assign io_samplesLeftAfterTrigger = samples_q;

`ifdef LA_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating malformed-packet counter
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= 8'h0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign io_errorCount = err_cnt_q;
`else
  assign io_errorCount = 8'h0;
`endif

endmodule

// File: tb/tb_la_packet_decoder.sv
// Scoreboard bench for la_packet_decoder.
// Honours LA_DECODER_ERRCNT_EN for the error-count expectation.
module tb_la_packet_decoder;
  import la_packet_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] samples;
  logic [7:0] errcnt;

  la_packet_decoder_if bus ();

  la_packet_decoder dut (
    .clk                        (clk),
    .reset                      (rst),
    .io_in_valid                (bus.in_valid),
    .io_in_ready                (bus.in_ready),
    .io_in_bits_last            (bus.in_last),
    .io_in_bits_fragment        (bus.in_frag),
    .io_cmd_valid               (bus.cmd_valid),
    .io_cmd_ready               (bus.cmd_ready),
    .io_cmd_opcode              (bus.cmd_opcode),
    .io_cmd_arg                 (bus.cmd_arg),
    .io_samplesLeftAfterTrigger (samples),
    .io_errorCount              (errcnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] sb[$];
  logic [7:0]  exp_samples = 8'h80;
  int          exp_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] err_exp();
`ifdef LA_DECODER_ERRCNT_EN
    return (exp_err > 255) ? 32'hFF : 32'(exp_err);
`else
    return 32'h0;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_frag  = b;
    bus.in_last  = l;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op,
                          input logic [7:0] a0,
                          input logic [7:0] a1);
    sb.push_back({op, a1, a0});
    if (op == OP_SET_SAMPLES) exp_samples = a0;
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(op, 1'b0);
    send_byte(a0, 1'b0);
    send_byte(a1, 1'b1);
  endtask

  // Scoreboard: pop an expectation on every command handshake
  always @(negedge clk) begin
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      if (sb.size() == 0) begin
        check("cmd_unexpected", 1, 0);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        check("cmd_opcode", 32'(bus.cmd_opcode), 32'(e[23:16]));
        check("cmd_arg", 32'(bus.cmd_arg), 32'(e[15:0]));
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_frag   = 8'h0;
    bus.cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    check("rst_opcode", 32'(bus.cmd_opcode), 0);
    check("rst_arg", 32'(bus.cmd_arg), 0);
    check("rst_samples", 32'(samples), 32'h80);
    check("rst_errcnt", 32'(errcnt), 0);

    // Set-samples packet, one cycle latency
    send_pkt(8'h01, 8'h40, 8'h00);
    check("lat_cmd_valid", 32'(bus.cmd_valid), 1);
    check("emit_in_ready", 32'(bus.in_ready), 0);
    check("set_samples", 32'(samples), 32'h40);
    check("errcnt_clean", 32'(errcnt), err_exp());

    // Header mismatch, then a good unknown-opcode packet
    send_byte(8'h55, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    exp_err++;
    check("hdr_err_cnt", 32'(errcnt), err_exp());
    check("hdr_no_cmd", 32'(bus.cmd_valid), 0);
    send_pkt(8'h07, 8'h34, 8'h12);
    check("unk_op_samples", 32'(samples), 32'(exp_samples));

    // Early last on opcode byte
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h02, 1'b1);
    exp_err++;
    check("early_last_cnt", 32'(errcnt), err_exp());
    check("early_last_rdy", 32'(bus.in_ready), 1);
    check("early_last_nocmd", 32'(bus.cmd_valid), 0);

    // Missing last on ARG1, recovered by a last byte in DROP
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h99, 1'b1);
    exp_err++;
    check("no_last_cnt", 32'(errcnt), err_exp());
    check("no_last_samples", 32'(samples), 32'(exp_samples));
    send_pkt(8'h03, 8'h5A, 8'hC3);

    // Back-pressure: ready low for 5 cycles
    @(posedge clk);
    #1;
    bus.cmd_ready = 1'b0;
    send_pkt(8'h01, 8'h25, 8'h9E);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.cmd_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_opcode", 32'(bus.cmd_opcode), 32'h01);
      check("bp_arg", 32'(bus.cmd_arg), 32'h9E25);
    end
    @(posedge clk);
    #1;
    bus.cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_released", 32'(bus.cmd_valid), 0);
    check("bp_samples", 32'(samples), 32'h25);

    // Reset after the opcode byte abandons the packet
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_samples = 8'h80;
    exp_err = 0;
    check("rst_mid_samples", 32'(samples), 32'h80);
    check("rst_mid_valid", 32'(bus.cmd_valid), 0);
    check("rst_mid_errcnt", 32'(errcnt), err_exp());
    send_pkt(8'h05, 8'hCD, 8'hAB);
    check("post_rst_samples", 32'(samples), 32'h80);

    // 256 bad single-byte packets saturate the counter
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00, 1'b1);
      exp_err++;
      if (i == 253) check("errcnt_fe", 32'(errcnt), err_exp());
    end
    check("errcnt_sat", 32'(errcnt), err_exp());
    check("sat_no_cmd", 32'(bus.cmd_valid), 0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/la_packet_decoder.md
LA_PACKET_DECODER -- requirements
Module: la_packet_decoder

Interface
REQ-001 SHALL have parameter HEADER, default 16'hAA55; packet header, sent low byte first.
REQ-002 SHALL have parameter SAMPLES_RESET, default 8'h80; reset value of io_samplesLeftAfterTrigger.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port io_in_valid, input, 1: inbound byte valid.
REQ-006 SHALL have port io_in_ready, output, 1: decoder accepts the inbound byte.
REQ-007 SHALL have port io_in_bits_last, input, 1: final byte of packet.
REQ-008 SHALL have port io_in_bits_fragment, input, 8: packet byte.
REQ-009 SHALL have port io_cmd_valid, output, 1: decoded command available.
REQ-010 SHALL have port io_cmd_ready, input, 1: consumer takes the command.
REQ-011 SHALL have port io_cmd_opcode, output, 8: decoded opcode.
REQ-012 SHALL have port io_cmd_arg, output, 16: decoded argument, {ARG1, ARG0}.
REQ-013 SHALL have port io_samplesLeftAfterTrigger, output, 8: config register for the logger.
REQ-014 SHALL have port io_errorCount, output, 8: malformed-packet count.

Function
REQ-015 SHALL accept a byte on each clock edge where io_in_valid and io_in_ready are both high.
REQ-016 SHALL define a valid packet as exactly 5 bytes: HEADER[7:0], HEADER[15:8], OPCODE, ARG0, ARG1, with last set only on ARG1.
REQ-017 SHALL implement states HEAD0, HEAD1, OPCODE, ARG0, ARG1, EMIT and DROP, advancing one state per accepted byte in that order, from HEAD0 to ARG1 to EMIT.
REQ-018 SHALL hold io_in_ready high in every state except EMIT, and low in EMIT.
REQ-019 SHALL treat as an error: a header byte mismatch; last set on any byte before ARG1; last clear on ARG1.
REQ-020 SHALL, on an error byte with last set, go to HEAD0; on an error byte with last clear, go to DROP.
REQ-021 SHALL, in DROP, discard bytes until a byte with last set is accepted, then go to HEAD0.
REQ-022 SHALL, in EMIT, assert io_cmd_valid with opcode and arg held stable; io_cmd_valid is high in EMIT only.
REQ-023 SHALL, when io_cmd_valid and io_cmd_ready are both high, go to HEAD0 on the next cycle; a new packet is accepted from that cycle.
REQ-024 SHALL, on acceptance of a valid ARG1 byte with opcode 8'h01, load io_samplesLeftAfterTrigger with ARG0 on the same edge.
REQ-025 SHALL present io_cmd_valid one cycle after ARG1 is accepted, giving one cycle of command latency.
REQ-026 SHALL emit every well-formed packet, including unknown opcodes, as a command; only opcode 8'h01 changes io_samplesLeftAfterTrigger.
REQ-027 SHALL increment io_errorCount by one per error event, saturating at 8'hFF.

Reset
REQ-028 SHALL, on reset, set state to HEAD0, io_cmd_valid to 0, io_cmd_opcode to 0, io_cmd_arg to 0, io_samplesLeftAfterTrigger to SAMPLES_RESET and io_errorCount to 0.
REQ-029 SHALL, when reset is asserted mid-packet or in EMIT, abandon the packet and resume at HEAD0 with no command emitted; a partial packet is not counted as an error.

Configuration
REQ-030 SHALL compile the error counter only when LA_DECODER_ERRCNT_EN is defined; when undefined, io_errorCount is tied to 8'h0 and no counter register exists, and all other behaviour is unchanged.

Structure
REQ-031 SHALL place the state enum, opcode constants (OP_SET_SAMPLES = 8'h01) and the default header in the shared logic-analyser package.
REQ-032 SHALL be a single flat module with no sub-modules.

Verification
REQ-033 SHALL verify: bytes 55,AA,01,40,00 (last on 00) -> one command with opcode 01 and arg 0040, io_samplesLeftAfterTrigger = 40, io_errorCount = 0.
REQ-034 SHALL verify: bytes 55,AB,xx,xx (last on final byte) -> no command, io_errorCount = 1, and a following valid packet decodes normally.
REQ-035 SHALL verify: bytes 55,AA,02 with last on 02 -> error counted, state returns to HEAD0, no command.
REQ-036 SHALL verify: valid packet with io_cmd_ready held low for 5 cycles -> io_cmd_valid and outputs stable, io_in_ready = 0 throughout, released on the ready handshake.
REQ-037 SHALL verify: 256 consecutive bad packets -> io_errorCount saturates at FF (reads 0 when LA_DECODER_ERRCNT_EN is undefined).
REQ-038 SHALL verify: reset pulsed after OPCODE byte -> no command emitted, io_samplesLeftAfterTrigger = 80, and the next packet decodes correctly.
